// File: rtl/painel_if.sv
`default_nettype none
// ============================================================================
// Module  : painel_if
// Brief   : Keypad input and code/selection outputs of the front-panel stage.
// Revision: 1.0
// ============================================================================
interface painel_if;
    logic       tecla_prem;
    logic [3:0] tecla;
    logic [6:0] codigo;
    logic       codigo_pronto;
    logic [1:0] selecao;
    logic [1:0] n_digitos;
    logic [1:0] tentativas;
    logic       bloqueado;

    modport master (
        output tecla_prem, tecla,
        input  codigo, codigo_pronto, selecao, n_digitos, tentativas, bloqueado
    );

    modport slave (
        input  tecla_prem, tecla,
        output codigo, codigo_pronto, selecao, n_digitos, tentativas, bloqueado
    );
endinterface
`default_nettype wire

// File: rtl/painel_entrada.sv
`default_nettype none
// ============================================================================
// Module  : painel_entrada
// Brief   : Debounced keypad, two-digit code assembly, selection and lockout.
//           Optional idle timeout of partial entries: PAINEL_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module painel_entrada #(
    parameter int unsigned DEB_CICLOS     = 3,
    parameter int unsigned CODIGO_OK      = 17,
    parameter int unsigned MAX_TENT       = 3,
    parameter int unsigned BLOQ_CICLOS    = 30,
    parameter int unsigned TIMEOUT_CICLOS = 10
) (
    input  logic     CLK,
    input  logic     reset,
    input  logic     power,
    painel_if.slave  pif
);
    localparam int c_DEB_W = $clog2(DEB_CICLOS + 1);
    localparam int c_BLQ_W = $clog2(BLOQ_CICLOS + 1);

    localparam logic [c_DEB_W-1:0] c_DEB     = c_DEB_W'(DEB_CICLOS);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE = c_DEB_W'(1);
    localparam logic [c_BLQ_W-1:0] c_BLQ     = c_BLQ_W'(BLOQ_CICLOS);
    localparam logic [c_BLQ_W-1:0] c_BLQ_ONE = c_BLQ_W'(1);
    localparam logic [6:0]         c_OK_VAL  = 7'(CODIGO_OK);
    localparam logic [1:0]         c_MAX     = 2'(MAX_TENT);

    localparam logic [3:0] c_K_OK  = 4'hA;
    localparam logic [3:0] c_K_CLR = 4'hB;

    localparam logic [1:0] c_VAZIO    = 2'd0;
    localparam logic [1:0] c_UM       = 2'd1;
    localparam logic [1:0] c_DOIS     = 2'd2;
    localparam logic [1:0] c_BLOQUEIO = 2'd3;

    // ---------------- debouncer (ignores power) ----------------
    logic               r_armed;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic [3:0]         r_deb_key;
    logic [c_DEB_W-1:0] w_run;
    logic               w_evt;

    always_comb begin
        if (pif.tecla_prem && (r_deb_cnt != '0) && (pif.tecla == r_deb_key))
            w_run = r_deb_cnt + c_DEB_ONE;
        else
            w_run = c_DEB_ONE;
        w_evt = r_armed && pif.tecla_prem && (w_run == c_DEB);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_armed   <= 1'b1;
            r_deb_cnt <= '0;
            r_deb_key <= '0;
        end else if (r_armed) begin
            if (!pif.tecla_prem) begin
                r_deb_cnt <= '0;
            end else if (w_evt) begin
                r_armed   <= 1'b0;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= w_run;
                r_deb_key <= pif.tecla;
            end
        end else begin
            // Re-arm only after a full run of released samples.
            if (pif.tecla_prem) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt + c_DEB_ONE == c_DEB) begin
                r_armed   <= 1'b1;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
            end
        end
    end

    // ---------------- entry FSM ----------------
    logic [1:0]         r_state, w_state_next;
    logic [6:0]         r_valor, w_valor_next;
    logic [6:0]         r_codigo, w_codigo_next;
    logic               r_pronto, w_pronto_next;
    logic [1:0]         r_sel, w_sel_next;
    logic [1:0]         r_tent, w_tent_next;
    logic [c_BLQ_W-1:0] r_bloq_cnt, w_bloq_cnt_next;
    logic [1:0]         r_ndig, w_ndig_next;
    logic               r_bloq, w_bloq_next;

    logic       w_digito;
    logic       w_entrando;
    logic       w_acerto;
    logic [1:0] w_tent_inc;
    logic       w_lock;
    logic       w_tmo;

    assign w_digito   = (pif.tecla <= 4'd9);
    assign w_entrando = (r_state == c_UM) || (r_state == c_DOIS);
    assign w_acerto   = (r_valor == c_OK_VAL);
    assign w_tent_inc = r_tent + 2'd1;
    assign w_lock     = !w_acerto && (w_tent_inc == c_MAX);

`ifdef PAINEL_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    logic [c_TMO_W-1:0] r_idle;

    always_ff @(posedge CLK) begin
        if (reset || !power || w_evt || !w_entrando)
            r_idle <= '0;
        else
            r_idle <= r_idle + c_TMO_ONE;
    end

    assign w_tmo = w_entrando && !w_evt && (r_idle == c_TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= c_VAZIO;
            r_valor    <= '0;
            r_codigo   <= '0;
            r_pronto   <= 1'b0;
            r_sel      <= '0;
            r_tent     <= '0;
            r_bloq_cnt <= '0;
            r_ndig     <= '0;
            r_bloq     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_valor    <= w_valor_next;
            r_codigo   <= w_codigo_next;
            r_pronto   <= w_pronto_next;
            r_sel      <= w_sel_next;
            r_tent     <= w_tent_next;
            r_bloq_cnt <= w_bloq_cnt_next;
            r_ndig     <= w_ndig_next;
            r_bloq     <= w_bloq_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!power) begin
            w_state_next = c_VAZIO;
        end else if (r_state == c_BLOQUEIO) begin
            // Events arriving on the expiry cycle are dropped with the rest.
            if (r_bloq_cnt == c_BLQ_ONE)
                w_state_next = c_VAZIO;
        end else if (w_evt) begin
            if (w_digito) begin
                if (r_state == c_VAZIO)
                    w_state_next = c_UM;
                else if (r_state == c_UM)
                    w_state_next = c_DOIS;
            end else if (pif.tecla == c_K_CLR) begin
                w_state_next = c_VAZIO;
            end else if ((pif.tecla == c_K_OK) && w_entrando) begin
                w_state_next = w_lock ? c_BLOQUEIO : c_VAZIO;
            end
        end else if (w_tmo) begin
            w_state_next = c_VAZIO;
        end
    end

    always_comb begin
        w_valor_next    = r_valor;
        w_codigo_next   = r_codigo;
        w_pronto_next   = 1'b0;
        w_sel_next      = r_sel;
        w_tent_next     = r_tent;
        w_bloq_cnt_next = r_bloq_cnt;
        if (!power) begin
            w_valor_next    = '0;
            w_codigo_next   = '0;
            w_sel_next      = '0;
            w_tent_next     = '0;
            w_bloq_cnt_next = '0;
        end else if (r_state == c_BLOQUEIO) begin
            w_bloq_cnt_next = r_bloq_cnt - c_BLQ_ONE;
        end else if (w_evt) begin
            if (w_digito) begin
                if (r_state == c_VAZIO)
                    w_valor_next = {3'b000, pif.tecla};
                else if (r_state == c_UM)
                    w_valor_next = r_valor * 7'd10 + {3'b000, pif.tecla};
            end else if (pif.tecla == c_K_CLR) begin
                w_valor_next = '0;
            end else if (pif.tecla == c_K_OK) begin
                if (w_entrando) begin
                    w_codigo_next = r_valor;
                    w_pronto_next = 1'b1;
                    w_valor_next  = '0;
                    if (w_acerto || w_lock)
                        w_tent_next = '0;
                    else
                        w_tent_next = w_tent_inc;
                    if (w_lock)
                        w_bloq_cnt_next = c_BLQ;
                end
            end else begin
                case (pif.tecla)
                    4'hC:    w_sel_next = 2'b01;
                    4'hD:    w_sel_next = 2'b10;
                    4'hE:    w_sel_next = 2'b11;
                    default: w_sel_next = r_sel;
                endcase
            end
        end else if (w_tmo) begin
            w_valor_next = '0;
        end

        case (w_state_next)
            c_UM:    w_ndig_next = 2'd1;
            c_DOIS:  w_ndig_next = 2'd2;
            default: w_ndig_next = 2'd0;
        endcase
        w_bloq_next = (w_state_next == c_BLOQUEIO);
    end

    assign pif.codigo        = r_codigo;
    assign pif.codigo_pronto = r_pronto;
    assign pif.selecao       = r_sel;
    assign pif.n_digitos     = r_ndig;
    assign pif.tentativas    = r_tent;
    assign pif.bloqueado     = r_bloq;
endmodule
`default_nettype wire

// File: tb/tb_painel_entrada.sv
`default_nettype none
// ============================================================================
// Module  : tb_painel_entrada
// Brief   : Directed keypad sequences with a queue-based scoreboard for
//           confirmed codes and lockout lengths.
// Revision: 1.0
// ============================================================================
module tb_painel_entrada;
    logic CLK = 1'b0;
    logic reset;
    logic power;

    painel_if pif ();

    painel_entrada dut (
        .CLK   (CLK),
        .reset (reset),
        .power (power),
        .pif   (pif)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] exp_codigo_q[$];
    int         exp_bloq_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge CLK);
        pif.tecla      = k;
        pif.tecla_prem = 1'b1;
        repeat (3) @(negedge CLK);
        pif.tecla_prem = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    // Monitor: every code pulse and every completed lockout run is scored.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge CLK);
            if (pif.codigo_pronto === 1'b1) begin
                if (exp_codigo_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pronto_inesperado: got codigo=%0d, expected no pulse", pif.codigo);
                end else begin
                    check("codigo", int'(pif.codigo), int'(exp_codigo_q.pop_front()));
                end
            end
            if (pif.bloqueado === 1'b1) begin
                run++;
            end else if (run != 0) begin
                if (exp_bloq_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL bloq_inesperado: got run=%0d, expected no lockout", run);
                end else begin
                    check("bloq_ciclos", run, exp_bloq_q.pop_front());
                end
                run = 0;
            end
        end
    end

    initial begin
        int  waited;
        reset          = 1'b1;
        power          = 1'b1;
        pif.tecla_prem = 1'b0;
        pif.tecla      = 4'h0;
        repeat (2) @(negedge CLK);
        check("rst_codigo",     int'(pif.codigo), 0);
        check("rst_pronto",     int'(pif.codigo_pronto), 0);
        check("rst_selecao",    int'(pif.selecao), 0);
        check("rst_n_digitos",  int'(pif.n_digitos), 0);
        check("rst_tentativas", int'(pif.tentativas), 0);
        check("rst_bloqueado",  int'(pif.bloqueado), 0);
        reset = 1'b0;

        // Correct code 17
        press(4'h1);
        check("ndig_apos_1", int'(pif.n_digitos), 1);
        exp_codigo_q.push_back(7'd17);
        press(4'h7);
        press(4'hA);
        check("tent_apos_17", int'(pif.tentativas), 0);
        check("ndig_apos_ok", int'(pif.n_digitos), 0);

        // Glitches of 1 and 2 cycles, then key 5 held 20 cycles
        @(negedge CLK);
        pif.tecla      = 4'h5;
        pif.tecla_prem = 1'b1;
        @(negedge CLK);
        pif.tecla_prem = 1'b0;
        repeat (3) @(negedge CLK);
        pif.tecla_prem = 1'b1;
        repeat (2) @(negedge CLK);
        pif.tecla_prem = 1'b0;
        repeat (3) @(negedge CLK);
        check("glitch_sem_evento", int'(pif.n_digitos), 0);
        pif.tecla_prem = 1'b1;
        repeat (20) @(negedge CLK);
        pif.tecla_prem = 1'b0;
        repeat (3) @(negedge CLK);
        check("held_um_evento", int'(pif.n_digitos), 1);
        press(4'hB);
        check("clear_ndig", int'(pif.n_digitos), 0);

        // Three wrong codes -> lockout
        press(4'hC);
        check("sel_curto", int'(pif.selecao), 1);
        exp_codigo_q.push_back(7'd12);
        press(4'h1); press(4'h2); press(4'hA);
        check("tent_1", int'(pif.tentativas), 1);
        exp_codigo_q.push_back(7'd3);
        press(4'h3); press(4'hA);
        check("tent_2", int'(pif.tentativas), 2);
        exp_codigo_q.push_back(7'd45);
        exp_bloq_q.push_back(30);
        press(4'h4); press(4'h5); press(4'hA);
        check("bloq_ativo", int'(pif.bloqueado), 1);
        press(4'h2);
        press(4'hD);
        check("bloq_ndig", int'(pif.n_digitos), 0);
        waited = 0;
        while (pif.bloqueado === 1'b1 && waited < 60) begin
            @(negedge CLK);
            waited++;
        end
        if (pif.bloqueado === 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL bloq_timeout: got bloqueado=1 after %0d cycles, expected release", waited);
        end
        check("pos_bloq_ndig", int'(pif.n_digitos), 0);
        check("pos_bloq_tent", int'(pif.tentativas), 0);
        check("pos_bloq_sel",  int'(pif.selecao), 1);

        // Power drop mid-entry
        press(4'hE);
        check("sel_longo", int'(pif.selecao), 3);
        press(4'h8);
        check("ndig_8", int'(pif.n_digitos), 1);
        @(negedge CLK);
        power = 1'b0;
        @(negedge CLK);
        power = 1'b1;
        check("pwr_ndig",   int'(pif.n_digitos), 0);
        check("pwr_sel",    int'(pif.selecao), 0);
        check("pwr_codigo", int'(pif.codigo), 0);
        exp_codigo_q.push_back(7'd17);
        press(4'h1); press(4'h7); press(4'hA);

        // Third digit ignored; OK with empty entry produces nothing
        exp_codigo_q.push_back(7'd42);
        press(4'h4); press(4'h2);
        check("ndig_2", int'(pif.n_digitos), 2);
        press(4'h9); press(4'hA);
        check("tent_42", int'(pif.tentativas), 1);
        press(4'hA);
        check("ok_vazio_tent", int'(pif.tentativas), 1);

        // Partial entry left idle
        press(4'h3);
        repeat (15) @(negedge CLK);
`ifdef PAINEL_TIMEOUT_EN
        check("idle_ndig", int'(pif.n_digitos), 0);
`else
        check("idle_ndig", int'(pif.n_digitos), 1);
`endif
        press(4'hB);

        repeat (5) @(negedge CLK);
        check("codigo_pendente", exp_codigo_q.size(), 0);
        check("bloq_pendente",   exp_bloq_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
